// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential multiply / result bank block.
package seq_mult_pkg;

  // Multiply engine states: waiting, shift-add iterations, bank write.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Width of a full product of two DATA_W-bit operands.
  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: one partial product per cycle for DATA_W
// cycles, then a single WRITE cycle in which the product is presented with
// a one-cycle valid pulse.
module shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data_in_0,
  input  logic [DATA_W-1:0]     data_in_1,
  output logic                  busy,
  output logic                  valid,
  output logic [2*DATA_W-1:0]   product
);

  localparam int PROD_W = prod_w(DATA_W);
  localparam int CNT_W  = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                last_iter;

  // The final RUN iteration uses counter value DATA_W-1.
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

  // State register; reset abandons any in-flight multiply.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for DATA_W cycles, WRITE once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy  = (state_q != IDLE);
    valid = (state_q == WRITE);
  end

  // Datapath next values: latch operands on start, one shift-add step per RUN cycle.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = data_in_0;
          mplier_d = data_in_1;
          cnt_d    = '0;
          prod_d   = '0;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + ({{DATA_W{1'b0}}, mcand_q} << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/seq_mult_bank.sv
// Multiply-and-store top: feeds the shift-add engine, writes or accumulates
// its product into an addressed result bank, and serves a registered read port.
module seq_mult_bank
  import seq_mult_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  start,
  input  logic                  acc_en,
  input  logic [DATA_W-1:0]     data_in_0,
  input  logic [DATA_W-1:0]     data_in_1,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   rd_data
);

  localparam int PROD_W = prod_w(DATA_W);

  logic                accept;
  logic                mult_valid;
  logic [PROD_W-1:0]   mult_product;

  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                acc_en_q, acc_en_d;
  logic [PROD_W-1:0]   bank_q [DEPTH];
  logic [PROD_W-1:0]   bank_d [DEPTH];
  logic [PROD_W-1:0]   rd_data_q, rd_data_d;

  // A request is taken only while the engine is idle and the block is selected.
  assign accept = cs && start && !busy;

  shift_add_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .data_in_0 (data_in_0),
    .data_in_1 (data_in_1),
    .busy      (busy),
    .valid     (mult_valid),
    .product   (mult_product)
  );

  assign done = mult_valid;

  // Capture destination and write mode alongside the operands.
  always_comb begin
    wr_addr_d = wr_addr_q;
    acc_en_d  = acc_en_q;
    if (accept) begin
      wr_addr_d = wr_addr;
      acc_en_d  = acc_en;
    end
  end

  // Bank update in the WRITE cycle: overwrite or wrap-around accumulate.
  always_comb begin
    bank_d = bank_q;
    if (mult_valid) begin
      if (acc_en_q) bank_d[wr_addr_q] = bank_q[wr_addr_q] + mult_product;
      else          bank_d[wr_addr_q] = mult_product;
    end
  end

  // Read port samples the pre-write bank, so a same-address read sees old data.
  always_comb begin
    rd_data_d = rd_data_q;
    if (cs) rd_data_d = bank_q[rd_addr];
  end

  // Request capture, bank and read registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr_q <= '0;
      acc_en_q  <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      wr_addr_q <= wr_addr_d;
      acc_en_q  <= acc_en_d;
      rd_data_q <= rd_data_d;
      bank_q    <= bank_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_seq_mult_bank.sv
// Directed bench for seq_mult_bank with hand-computed expected values.
module tb_seq_mult_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        start;
  logic        acc_en;
  logic [7:0]  data_in_0;
  logic [7:0]  data_in_1;
  logic [3:0]  wr_addr;
  logic [3:0]  rd_addr;
  logic        busy;
  logic        done;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;

  seq_mult_bank dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .start     (start),
    .acc_en    (acc_en),
    .data_in_0 (data_in_0),
    .data_in_1 (data_in_1),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] addr, input logic [15:0] exp, input string tag);
    rd_addr = addr;
    tick();
    chk(tag, {16'd0, rd_data}, {16'd0, exp});
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] addr, input logic acc);
    data_in_0 = a;
    data_in_1 = b;
    wr_addr   = addr;
    acc_en    = acc;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; returns the cycle in which done is seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] addr, input logic acc, input string tag);
    int lat;
    issue(a, b, addr, acc);
    wait_done(lat);
    chk(tag, lat, 9);
    tick();
  endtask

  initial begin
    int npulse;
    reset = 1'b1; cs = 1'b0; start = 1'b0; acc_en = 1'b0;
    data_in_0 = '0; data_in_1 = '0; wr_addr = '0; rd_addr = '0;

    // 1: reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd_data", {16'd0, rd_data}, 0);
    cs = 1'b1;
    for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000, "rst_bank");

    // 2: basic multiply with exact busy/done timing
    issue(8'h13, 8'h03, 4'd0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      chk("basic_busy", {31'd0, busy}, 1);
      chk("basic_done", {31'd0, done}, (i == 9) ? 1 : 0);
      tick();
    end
    chk("basic_idle", {31'd0, busy}, 0);
    chk("basic_done_low", {31'd0, done}, 0);
    rd(4'd0, 16'h0039, "basic_result");

    // 3: accumulate with wrap, then accumulate zero
    run_op(8'hFF, 8'hFF, 4'd5, 1'b0, "lat_ff_load");
    rd(4'd5, 16'hFE01, "ff_load");
    run_op(8'hFF, 8'hFF, 4'd5, 1'b1, "lat_ff_acc");
    rd(4'd5, 16'hFC02, "ff_acc_wrap");
    run_op(8'h00, 8'hAB, 4'd5, 1'b1, "lat_zero_acc");
    rd(4'd5, 16'hFC02, "zero_acc");

    // 4a: start while busy is ignored
    issue(8'h02, 8'h03, 4'd1, 1'b0);
    tick(); tick();
    data_in_0 = 8'h05; data_in_1 = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) npulse++;
      tick();
    end
    chk("busy_reject_pulses", npulse, 1);
    chk("busy_reject_idle", {31'd0, busy}, 0);
    rd(4'd1, 16'h0006, "busy_reject_result");

    // 4b: start with cs low is ignored
    cs = 1'b0;
    issue(8'h07, 8'h07, 4'd1, 1'b0);
    chk("cs_low_no_busy", {31'd0, busy}, 0);
    tick(); tick();
    chk("cs_low_still_idle", {31'd0, busy}, 0);
    cs = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    rd(4'd1, 16'h0006, "cs_low_bank");

    // 4c: read register holds while cs low
    rd(4'd0, 16'h0039, "hold_pre");
    cs = 1'b0;
    rd_addr = 4'd5;
    tick(); tick();
    chk("hold_cs_low", {16'd0, rd_data}, 32'h0039);
    cs = 1'b1;
    tick();
    chk("hold_release", {16'd0, rd_data}, 32'hFC02);

    // 5: reset in RUN cycle 4
    issue(8'h13, 8'h03, 4'd2, 1'b0);
    tick(); tick(); tick();
    chk("midrst_busy_before", {31'd0, busy}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) npulse++;
      tick();
    end
    chk("midrst_no_done", npulse, 0);
    rd(4'd2, 16'h0000, "midrst_entry2");
    rd(4'd0, 16'h0000, "midrst_bank_clear");

    // 6: read-during-write returns old contents
    rd_addr = 4'd7;
    begin
      int lat;
      issue(8'h10, 8'h10, 4'd7, 1'b0);
      wait_done(lat);
      chk("rdw_lat", lat, 9);
      chk("rdw_before", {16'd0, rd_data}, 32'h0000);
      tick();
      chk("rdw_old", {16'd0, rd_data}, 32'h0000);
      tick();
      chk("rdw_new", {16'd0, rd_data}, 32'h0100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
